// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter: FSM state
// encodings and the read word returned when an access times out.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_INST = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_e;

    // Returned to the requester in place of memory data on a watchdog timeout.
    localparam logic [31:0] ARB_FILL_WORD = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester arbiter/sequencer sharing one variable-latency memory bus
// between the instruction-fetch port and the load/store port.
// Optional feature: define ARB_TIMEOUT_EN to add a wait watchdog that
// completes a stuck access with ARB_FILL_WORD and raises a sticky err_o.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inst_req_i,
    input  logic [AW-1:0]   inst_addr_i,
    output logic            inst_ack_o,
    output logic [DW-1:0]   inst_rdata_o,
    input  logic            data_req_i,
    input  logic            data_we_i,
    input  logic [AW-1:0]   data_addr_i,
    input  logic [DW/8-1:0] data_sel_i,
    input  logic [DW-1:0]   data_wdata_i,
    output logic            data_ack_o,
    output logic [DW-1:0]   data_rdata_o,
    output logic            mem_ce_o,
    output logic            mem_we_o,
    output logic [AW-1:0]   mem_addr_o,
    output logic [DW/8-1:0] mem_sel_o,
    output logic [DW-1:0]   mem_wdata_o,
    input  logic [DW-1:0]   mem_rdata_i,
    input  logic            mem_ack_i,
    output logic            stallreq_o,
    output logic            err_o
);

    localparam int unsigned SW = DW / 8;

    arb_state_e    state_q, state_d;
    logic          last_data_q, last_data_d;
    logic          mem_ce_q, mem_ce_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [SW-1:0] mem_sel_q, mem_sel_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          inst_ack_q, inst_ack_d;
    logic [DW-1:0] inst_rdata_q, inst_rdata_d;
    logic          data_ack_q, data_ack_d;
    logic [DW-1:0] data_rdata_q, data_rdata_d;

    // Completion of the granted access this cycle and the word handed back.
    logic          done;
    logic [DW-1:0] done_rdata;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CntW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
`endif

    // Next-state, grant decision and bus/response register updates.
    always_comb begin
        state_d      = state_q;
        last_data_d  = last_data_q;
        mem_ce_d     = mem_ce_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_sel_d    = mem_sel_q;
        mem_wdata_d  = mem_wdata_q;
        inst_ack_d   = 1'b0;
        inst_rdata_d = inst_rdata_q;
        data_ack_d   = 1'b0;
        data_rdata_d = data_rdata_q;
        done         = 1'b0;
        done_rdata   = mem_rdata_i;
`ifdef ARB_TIMEOUT_EN
        cnt_d        = cnt_q;
        err_d        = err_q;
`endif

        unique case (state_q)
            ARB_IDLE: begin
                // Data wins a tie unless it also won the previous grant.
                if (data_req_i && (!inst_req_i || !last_data_q)) begin
                    state_d     = ARB_DATA;
                    last_data_d = 1'b1;
                    mem_ce_d    = 1'b1;
                    mem_we_d    = data_we_i;
                    mem_addr_d  = data_addr_i;
                    mem_sel_d   = data_sel_i;
                    mem_wdata_d = data_wdata_i;
`ifdef ARB_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end else if (inst_req_i) begin
                    state_d     = ARB_INST;
                    last_data_d = 1'b0;
                    mem_ce_d    = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = inst_addr_i;
                    mem_sel_d   = '1;
                    mem_wdata_d = '0;
`ifdef ARB_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end
            end
            ARB_INST, ARB_DATA: begin
                if (mem_ack_i) begin
                    done = 1'b1;
`ifdef ARB_TIMEOUT_EN
                end else if (cnt_q == CntW'(TIMEOUT)) begin
                    done       = 1'b1;
                    done_rdata = DW'(ARB_FILL_WORD);
                    err_d      = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            default: state_d = ARB_IDLE;
        endcase

        if (done) begin
            state_d  = ARB_IDLE;
            mem_ce_d = 1'b0;
            if (state_q == ARB_INST) begin
                inst_ack_d   = 1'b1;
                inst_rdata_d = done_rdata;
            end else begin
                data_ack_d   = 1'b1;
                data_rdata_d = done_rdata;
            end
        end
    end

    // State and output registers; reset abandons any in-flight access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            last_data_q  <= 1'b0;
            mem_ce_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_sel_q    <= '0;
            mem_wdata_q  <= '0;
            inst_ack_q   <= 1'b0;
            inst_rdata_q <= '0;
            data_ack_q   <= 1'b0;
            data_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            last_data_q  <= last_data_d;
            mem_ce_q     <= mem_ce_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_sel_q    <= mem_sel_d;
            mem_wdata_q  <= mem_wdata_d;
            inst_ack_q   <= inst_ack_d;
            inst_rdata_q <= inst_rdata_d;
            data_ack_q   <= data_ack_d;
            data_rdata_q <= data_rdata_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Wait counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    // Timeout configuration is only consumed when the watchdog is built in.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^{TIMEOUT, ARB_FILL_WORD};
    assign err_o              = 1'b0;
`endif

    assign mem_ce_o     = mem_ce_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_sel_o    = mem_sel_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign inst_ack_o   = inst_ack_q;
    assign inst_rdata_o = inst_rdata_q;
    assign data_ack_o   = data_ack_q;
    assign data_rdata_o = data_rdata_q;

    // Combinational so the stall drops in the same cycle as the ack pulse.
    assign stallreq_o = (inst_req_i & ~inst_ack_q) | (data_req_i & ~data_ack_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, scoreboarded bench for mem_arbiter with a behavioural
// variable-latency memory. Grants and read responses are predicted when
// stimulus is driven and compared as the DUT produces them.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req_i;
    logic [31:0] inst_addr_i;
    logic        inst_ack_o;
    logic [31:0] inst_rdata_o;
    logic        data_req_i;
    logic        data_we_i;
    logic [31:0] data_addr_i;
    logic [3:0]  data_sel_i;
    logic [31:0] data_wdata_i;
    logic        data_ack_o;
    logic [31:0] data_rdata_o;
    logic        mem_ce_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_sel_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i = '0;
    logic        mem_ack_i = 1'b0;
    logic        stallreq_o;
    logic        err_o;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        bit          is_data;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] wdata;
    } grant_t;

    typedef struct {
        logic [31:0] rdata;
        bit          care;
    } resp_t;

    grant_t gq[$];
    resp_t  iq[$];
    resp_t  dq[$];

    // Memory model knobs.
    int mem_wait = 0;
    bit mem_hang = 1'b0;
    int wcnt     = 0;

    mem_arbiter #(
        .AW(32),
        .DW(32),
        .TIMEOUT(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .inst_req_i(inst_req_i),
        .inst_addr_i(inst_addr_i),
        .inst_ack_o(inst_ack_o),
        .inst_rdata_o(inst_rdata_o),
        .data_req_i(data_req_i),
        .data_we_i(data_we_i),
        .data_addr_i(data_addr_i),
        .data_sel_i(data_sel_i),
        .data_wdata_i(data_wdata_i),
        .data_ack_o(data_ack_o),
        .data_rdata_o(data_rdata_o),
        .mem_ce_o(mem_ce_o),
        .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o),
        .mem_sel_o(mem_sel_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i),
        .mem_ack_i(mem_ack_i),
        .stallreq_o(stallreq_o),
        .err_o(err_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h3401_1104;
    endfunction

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_grant(input bit is_data, input logic [31:0] addr, input logic we,
                              input logic [3:0] sel, input logic [31:0] wdata);
        grant_t g;
        g.is_data = is_data;
        g.addr    = addr;
        g.we      = we;
        g.sel     = sel;
        g.wdata   = wdata;
        gq.push_back(g);
    endtask

    task automatic push_resp(input bit is_data, input logic [31:0] rdata, input bit care);
        resp_t r;
        r.rdata = rdata;
        r.care  = care;
        if (is_data) dq.push_back(r);
        else iq.push_back(r);
    endtask

    // Memory: acks after mem_wait extra cycles of mem_ce_o, never if hung.
    always @(posedge clk) begin
        #1;
        if (mem_ack_i || !mem_ce_o) begin
            mem_ack_i = 1'b0;
            wcnt      = 0;
        end else if (!mem_hang) begin
            if (wcnt == mem_wait) begin
                mem_ack_i   = 1'b1;
                mem_rdata_i = mem_word(mem_addr_o);
            end else begin
                wcnt++;
            end
        end
    end

    // Scoreboard monitor: new grants and ack pulses against predictions.
    bit ce_prev = 1'b0;
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            if (mem_ce_o && !ce_prev) begin
                if (gq.size() == 0) begin
                    chk("unexpected_grant", {40'd0, mem_addr_o}, 72'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    grant_t g;
                    g = gq.pop_front();
                    chk("grant_bus", {31'd0, mem_we_o, mem_addr_o, 4'd0, mem_sel_o},
                        {31'd0, g.we, g.addr, 4'd0, g.sel});
                    if (g.is_data) chk("grant_wdata", {40'd0, mem_wdata_o}, {40'd0, g.wdata});
                end
            end
            if (inst_ack_o) begin
                if (iq.size() == 0) begin
                    chk("unexpected_inst_ack", 72'd1, 72'd0);
                end else begin
                    resp_t r;
                    r = iq.pop_front();
                    chk("inst_rdata", {40'd0, inst_rdata_o}, {40'd0, r.rdata});
                end
            end
            if (data_ack_o) begin
                if (dq.size() == 0) begin
                    chk("unexpected_data_ack", 72'd1, 72'd0);
                end else begin
                    resp_t r;
                    r = dq.pop_front();
                    if (r.care) chk("data_rdata", {40'd0, data_rdata_o}, {40'd0, r.rdata});
                end
            end
        end
        ce_prev = mem_ce_o;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks;
        bit seen;

        rst          = 1'b1;
        inst_req_i   = 1'b0;
        inst_addr_i  = '0;
        data_req_i   = 1'b0;
        data_we_i    = 1'b0;
        data_addr_i  = '0;
        data_sel_i   = '0;
        data_wdata_i = '0;

        // Reset state: every output low.
        repeat (2) @(negedge clk);
        chk("reset_outputs",
            {mem_ce_o, mem_we_o, mem_addr_o, mem_sel_o, inst_ack_o, data_ack_o, err_o, stallreq_o},
            72'd0);
        chk("reset_rdata_wdata", {8'd0, inst_rdata_o, data_rdata_o | mem_wdata_o}, 72'd0);
        rst = 1'b0;

        // Zero-wait fetch from address 4.
        @(negedge clk);
        inst_req_i  = 1'b1;
        inst_addr_i = 32'h0000_0004;
        push_grant(1'b0, 32'h4, 1'b0, 4'hF, 32'h0);
        push_resp(1'b0, 32'h3401_1100, 1'b1);
        #1;
        chk("t1_stall_at_req", {71'd0, stallreq_o}, 72'd1);
        chk("t1_ce_at_req", {71'd0, mem_ce_o}, 72'd0);
        @(negedge clk);
        chk("t1_ce_next", {69'd0, mem_ce_o, stallreq_o, inst_ack_o}, {69'd0, 3'b110});
        @(negedge clk);
        chk("t1_ack", {38'd0, inst_ack_o, stallreq_o, inst_rdata_o},
            {38'd0, 2'b10, 32'h3401_1100});
        inst_req_i = 1'b0;
        @(negedge clk);
        chk("t1_after", {70'd0, mem_ce_o, inst_ack_o}, 72'd0);

        // Both requesters held: grants alternate DATA, INST, DATA.
        mem_wait = 1;
        @(negedge clk);
        inst_req_i   = 1'b1;
        inst_addr_i  = 32'h0000_0004;
        data_req_i   = 1'b1;
        data_we_i    = 1'b0;
        data_addr_i  = 32'h0000_0020;
        data_sel_i   = 4'hF;
        data_wdata_i = 32'h5555_0000;
        push_grant(1'b1, 32'h20, 1'b0, 4'hF, 32'h5555_0000);
        push_grant(1'b0, 32'h4, 1'b0, 4'hF, 32'h0);
        push_grant(1'b1, 32'h20, 1'b0, 4'hF, 32'h5555_0000);
        push_resp(1'b1, mem_word(32'h20), 1'b1);
        push_resp(1'b0, mem_word(32'h4), 1'b1);
        push_resp(1'b1, mem_word(32'h20), 1'b1);
        acks = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (inst_ack_o || data_ack_o) acks++;
            if (acks == 3) break;
        end
        chk("t2_ack_count", 72'(acks), 72'd3);
        inst_req_i = 1'b0;
        data_req_i = 1'b0;
        @(negedge clk);
        chk("t2_idle_after", {71'd0, mem_ce_o}, 72'd0);

        // Store with three wait cycles: bus held for four cycles.
        mem_wait = 3;
        @(negedge clk);
        data_req_i   = 1'b1;
        data_we_i    = 1'b1;
        data_addr_i  = 32'h0000_0010;
        data_sel_i   = 4'b0011;
        data_wdata_i = 32'h0000_ABCD;
        push_grant(1'b1, 32'h10, 1'b1, 4'b0011, 32'h0000_ABCD);
        push_resp(1'b1, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("t3_bus_c%0d", i),
                {mem_ce_o, mem_we_o, mem_addr_o, mem_sel_o, mem_wdata_o, data_ack_o, 1'b0},
                {1'b1, 1'b1, 32'h10, 4'b0011, 32'h0000_ABCD, 1'b0, 1'b0});
        end
        @(negedge clk);
        chk("t3_ack", {70'd0, data_ack_o, mem_ce_o}, {70'd0, 2'b10});
        data_req_i = 1'b0;
        data_we_i  = 1'b0;

        // Reset while DATA awaits an ack that never comes.
        mem_hang = 1'b1;
        @(negedge clk);
        data_req_i  = 1'b1;
        data_addr_i = 32'h0000_0040;
        data_sel_i  = 4'hF;
        push_grant(1'b1, 32'h40, 1'b0, 4'hF, data_wdata_i);
        repeat (2) @(negedge clk);
        chk("t4_waiting", {71'd0, mem_ce_o}, 72'd1);
        rst        = 1'b1;
        data_req_i = 1'b0;
        @(negedge clk);
        chk("t4_reset_outputs",
            {mem_ce_o, mem_we_o, mem_addr_o, mem_sel_o, inst_ack_o, data_ack_o, err_o, stallreq_o},
            72'd0);
        chk("t4_reset_rdata_wdata", {8'd0, inst_rdata_o, data_rdata_o | mem_wdata_o}, 72'd0);
        rst      = 1'b0;
        mem_hang = 1'b0;
        mem_wait = 1;
        @(negedge clk);
        inst_req_i  = 1'b1;
        inst_addr_i = 32'h0000_0008;
        push_grant(1'b0, 32'h8, 1'b0, 4'hF, 32'h0);
        push_resp(1'b0, mem_word(32'h8), 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (inst_ack_o) begin
                seen = 1'b1;
                break;
            end
        end
        chk("t4_fetch_after_reset", {71'd0, seen}, 72'd1);
        inst_req_i = 1'b0;

`ifdef ARB_TIMEOUT_EN
        // Memory never acks: watchdog completes with the fill word.
        mem_hang = 1'b1;
        @(negedge clk);
        inst_req_i  = 1'b1;
        inst_addr_i = 32'h0000_000C;
        push_grant(1'b0, 32'hC, 1'b0, 4'hF, 32'h0);
        push_resp(1'b0, 32'hDEAD_BEEF, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (inst_ack_o) begin
                seen = 1'b1;
                break;
            end
        end
        chk("t5_timeout_ack", {71'd0, seen}, 72'd1);
        inst_req_i = 1'b0;
        mem_hang   = 1'b0;
        @(negedge clk);
        chk("t5_err_set", {71'd0, err_o}, 72'd1);
        repeat (3) @(negedge clk);
        chk("t5_err_sticky", {71'd0, err_o}, 72'd1);
`else
        chk("t5_err_low", {71'd0, err_o}, 72'd0);
`endif

        // Fetch dropped right after grant still completes exactly once.
        mem_wait = 2;
        @(negedge clk);
        inst_req_i  = 1'b1;
        inst_addr_i = 32'h0000_0100;
        push_grant(1'b0, 32'h100, 1'b0, 4'hF, 32'h0);
        push_resp(1'b0, mem_word(32'h100), 1'b1);
        @(negedge clk);
        chk("t6_granted", {71'd0, mem_ce_o}, 72'd1);
        inst_req_i = 1'b0;
        #1;
        chk("t6_stall_dropped", {71'd0, stallreq_o}, 72'd0);
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (inst_ack_o) acks++;
        end
        chk("t6_single_ack", 72'(acks), 72'd1);
        chk("t6_bus_idle", {71'd0, mem_ce_o}, 72'd0);

        chk("scoreboard_drained", 72'(gq.size() + iq.size() + dq.size()), 72'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
